// File: rtl/mux_select_arbiter_if.sv
// Requester/arbiter bundle for mux_select_arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface mux_select_arbiter_if #(
    parameter int N_REQ = 8
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-2:0] select;
    logic [2:0]       owner_id;
    logic             busy;
    logic             timeout_err;

    modport master (
        output req, done,
        input  grant, select, owner_id, busy, timeout_err
    );

    modport slave (
        input  req, done,
        output grant, select, owner_id, busy, timeout_err
    );
endinterface

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the select vector of an N:1 priority mux.
// Optional forced release after MAX_HOLD cycles: define MUX_ARB_TIMEOUT_EN.
module mux_select_arbiter_chk #(
    parameter int N_REQ = 8
) (
    input logic             clk,
    input logic             reset,
    input logic [N_REQ-1:0] grant,
    input logic [N_REQ-2:0] select,
    input logic             busy
);
    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    a_select_match:  assert property (@(posedge clk) disable iff (reset) select == grant[N_REQ-2:0]);
    a_busy_match:    assert property (@(posedge clk) disable iff (reset) busy == (|grant));
endmodule

module mux_select_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input logic                 clk,
    input logic                 reset,
    mux_select_arbiter_if.slave arb_bus
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);

    if ((N_REQ < 2) || (N_REQ > 8)) begin : g_bad_n_req
        $error("mux_select_arbiter: N_REQ must be in 2..8");
    end
    if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
        $error("mux_select_arbiter: CNT_W too narrow for MAX_HOLD");
    end

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-2:0] select_q, select_d;
    logic [2:0]       owner_q, owner_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic             busy_q, busy_d;
    logic             tout_q, tout_d;

    logic [3:0]       pick_s;
    logic [2:0]       next_ptr_s;
    logic [N_REQ-1:0] owner_bit_s;
    logic             owner_req_s;
    logic             owner_done_s;
    logic             release_s;
    logic             timeout_s;

    // First set bit of mask at or above start, wrapping; bit 3 flags a hit.
    function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] mask, input logic [2:0] start);
        logic [3:0] res;
        int         idx;
        logic [2:0] idx3;
        res = 4'b0000;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            idx3 = idx[2:0];
            if (mask[idx3]) begin
                res = {1'b1, idx3};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

`ifdef MUX_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    assign timeout_s = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    // Hold counter restarts on every fresh grant, including a regrant out of IDLE.
    always_comb begin
        hold_cnt_d = '0;
        if ((state_d == GRANT) && ((state_q == IDLE) || release_s)) begin
            hold_cnt_d = '0;
        end else if (state_q == GRANT) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end else begin
            hold_cnt_d = '0;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Owner bookkeeping used by the release decision.
    always_comb begin
        owner_bit_s          = '0;
        owner_bit_s[owner_q] = 1'b1;
        owner_req_s          = arb_bus.req[owner_q];
        owner_done_s         = arb_bus.done[owner_q];
        next_ptr_s           = (owner_q == LAST_IDX) ? 3'd0 : owner_q + 3'd1;
        release_s            = (state_q == GRANT) && (owner_done_s || !owner_req_s || timeout_s);
    end

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        busy_d   = busy_q;
        tout_d   = 1'b0;
        pick_s   = 4'b0000;
        case (state_q)
            IDLE: begin
                pick_s = rr_pick(arb_bus.req, rr_ptr_q);
                if (pick_s[3]) begin
                    grant_d            = '0;
                    grant_d[pick_s[2:0]] = 1'b1;
                    owner_d            = pick_s[2:0];
                    busy_d             = 1'b1;
                    state_d            = GRANT;
                end else begin
                    grant_d = '0;
                    owner_d = 3'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    // The outgoing owner is masked so a lone re-requester sees one idle bubble.
                    rr_ptr_d = next_ptr_s;
                    tout_d   = timeout_s && owner_req_s && !owner_done_s;
                    pick_s   = rr_pick(arb_bus.req & ~owner_bit_s, next_ptr_s);
                    if (pick_s[3]) begin
                        grant_d              = '0;
                        grant_d[pick_s[2:0]] = 1'b1;
                        owner_d              = pick_s[2:0];
                        busy_d               = 1'b1;
                        state_d              = GRANT;
                    end else begin
                        grant_d = '0;
                        owner_d = 3'd0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                owner_d  = 3'd0;
                rr_ptr_d = 3'd0;
                busy_d   = 1'b0;
            end
        endcase
        select_d = grant_d[N_REQ-2:0];
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            select_q <= '0;
            owner_q  <= 3'd0;
            rr_ptr_q <= 3'd0;
            busy_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            tout_q   <= tout_d;
        end
    end

    assign arb_bus.grant       = grant_q;
    assign arb_bus.select      = select_q;
    assign arb_bus.owner_id    = owner_q;
    assign arb_bus.busy        = busy_q;
    assign arb_bus.timeout_err = tout_q;

    mux_select_arbiter_chk #(.N_REQ(N_REQ)) u_chk (
        .clk    (clk),
        .reset  (reset),
        .grant  (grant_q),
        .select (select_q),
        .busy   (busy_q)
    );
endmodule
